seq_detector_param: RTL
=======================

SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL provide parameter N, default 4, meaning pattern length in bits (legal range 2..16).
REQ-002 SHALL provide parameter PATTERN, default 4'b1011 (N bits), meaning target sequence, MSB received first.
REQ-003 SHALL provide parameter CNT_W, default 8, meaning match counter width.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state updates on rising edge.
REQ-005 SHALL provide port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL provide port in_valid, input, 1, qualifies in_bit for the current cycle.
REQ-007 SHALL provide port in_bit, input, 1, serial data bit.
REQ-008 SHALL provide port overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
REQ-009 SHALL provide port clr_count, input, 1, synchronous clear of match_count.
REQ-010 SHALL provide port match, output, 1, Mealy (combinational) match indication.
REQ-011 SHALL provide port match_q, output, 1, registered copy of match.
REQ-012 SHALL provide port match_count, output, CNT_W, saturating count of detected matches.

Function
REQ-013 SHALL hold history register hist (N-1 bits, newest bit in LSB) and fill counter fill (0..N-1, saturating at N-1).
REQ-014 SHALL assert match = in_valid AND (fill == N-1) AND ({hist, in_bit} == PATTERN), combinationally in the same cycle the final pattern bit is presented.
REQ-015 SHALL, on a rising edge with in_valid=1, shift in_bit into hist and increment fill (saturating), unless REQ-016 applies.
REQ-016 SHALL, on a rising edge with match=1 and overlap=0, shift in_bit into hist and set fill to 0, so no bit of a detected pattern is reused.
REQ-017 SHALL, with overlap=1, reuse the trailing bits of a detected pattern (e.g. 1011011 yields two matches for PATTERN=1011).
REQ-018 SHALL, on a rising edge with in_valid=0, leave hist, fill, and match_count unchanged; match is 0 in that cycle.
REQ-019 SHALL register match_q <= match every rising edge (latency 1 cycle from match).
REQ-020 SHALL increment match_count by 1 on each rising edge where match=1, saturating at 2^CNT_W-1 (no wrap).
REQ-021 SHALL give clr_count priority over increment: clr_count=1 and match=1 in the same cycle leaves match_count = 0; the match is not counted; match and match_q still assert.
REQ-022 SHALL sample overlap every cycle; a change takes effect only on the next match decision.
REQ-023 SHALL never assert match before N valid bits have been received since reset or since the last non-overlapping match.

Reset
REQ-024 SHALL, while rst=0, force hist=0, fill=0, match_q=0, match_count=0 immediately, independent of clk.
REQ-025 SHALL hold match=0 while rst=0 (guaranteed by fill=0).
REQ-026 SHALL, on reset asserted mid-pattern, discard all partial history; detection restarts from the first valid bit after rst deasserts.

Verification
REQ-027 SHALL cover basic detection, N=4, PATTERN=1011: valid bits 1,0,1,1 -> match=1 during 4th bit cycle, match_q=1 next cycle, match_count=1.
REQ-028 SHALL cover overlap modes with bits 1,0,1,1,0,1,1: overlap=1 -> matches at bits 4 and 7, count=2; overlap=0 -> match at bit 4 only, count=1.
REQ-029 SHALL cover valid gaps and prefix retry: bits 1,(in_valid=0, in_bit=1),0,1,1 -> one match at last bit; bits 1,1,0,1,1 -> one match at bit 5.
REQ-030 SHALL cover reset mid-operation: bits 1,0,1, pulse rst=0 between edges, then bit 1 -> no match, outputs 0 during reset, count=0.
REQ-031 SHALL cover saturation and clear with CNT_W=2: five overlapping matches -> match_count=3 holds; clr_count=1 coincident with a match -> match_count=0 next edge, match_q=1.

Source files
------------

// File: rtl/seq_detector_param.sv
// Serial pattern detector with overlap control.
// Mealy match, registered copy and saturating match counter.
module seq_detector_param #(
  parameter int unsigned N = 4,
  parameter logic [N-1:0] PATTERN = 4'b1011,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             clr_count,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_count
);

  localparam int unsigned FW = $clog2(N);
  localparam logic [FW-1:0] FILL_MAX = FW'(N - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N-2:0]     hist_q, hist_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             match_d;
  logic [N-1:0]     window;

  assign window = {hist_q, in_bit};

  always_comb begin
    match_d = in_valid && (fill_q == FILL_MAX) && (window == PATTERN);
    hist_d  = hist_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    if (in_valid) begin
      hist_d = window[N-2:0];
      // Non-overlapping: a hit consumes every bit of the window.
      if (match_d && !overlap) begin
        fill_d = '0;
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
    if (clr_count) begin
      cnt_d = '0;
    end else if (match_d && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= match_d;
    end
  end

  assign match       = match_d;
  assign match_count = cnt_q;

endmodule
